// File: rtl/pipe_mem_wb_if.sv
// ============================================================================
//  Module      : pipe_mem_wb_if
//  Description : Data-memory req/ack bus between the MEM stage (master) and
//                the data memory (slave). Request, direction, address and
//                store data come from the master. Read data and a one-cycle
//                completion pulse come back from the slave.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_mem_wb_if #(
    parameter int WIDTH = 32
);
    logic             MEM_REQ;
    logic             MEM_WE;
    logic [WIDTH-1:0] MEM_ADDR;
    logic [WIDTH-1:0] MEM_WDATA;
    logic [WIDTH-1:0] MEM_RDATA;
    logic             MEM_ACK;

    // Pipeline side: drives the request, samples the response
    modport master (
        output MEM_REQ,
        output MEM_WE,
        output MEM_ADDR,
        output MEM_WDATA,
        input  MEM_RDATA,
        input  MEM_ACK
    );

    // Memory side: samples the request, drives the response
    modport slave (
        input  MEM_REQ,
        input  MEM_WE,
        input  MEM_ADDR,
        input  MEM_WDATA,
        output MEM_RDATA,
        output MEM_ACK
    );
endinterface

`default_nettype wire

// File: rtl/pipe_mem_wb.sv
// ============================================================================
//  Module      : pipe_mem_wb
//  Description : MEM stage plus MEM/WB pipeline register of the 32-bit core.
//                A load or store from EX/MEM becomes a single registered bus
//                request. The EX/MEM register is stalled until the memory
//                acknowledges, and MEM/WB receives bubbles in the meantime.
//                Non-memory instructions pass through in one cycle.
//  Options     : MEM_MISALIGN_EN - when defined, a load or store whose
//                address is not word aligned is not sent to the bus. It is
//                retired at once with REGWRITE_OUT=0 and MISALIGN_OUT=1.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_mem_wb #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,          // asynchronous, active low

    // EX/MEM register outputs
    input  wire logic             MEMWRITE_IN,
    input  wire logic             MEMTOREG_IN,
    input  wire logic             REGWRITE_IN,
    input  wire logic [WIDTH-1:0] RESULTOP_IN,
    input  wire logic [WIDTH-1:0] WRDATA_IN,
    input  wire logic [4:0]       ARD_IN,

    // Holds EX/MEM while a memory access is in progress
    output logic                  STALL_OUT,

    // Data-memory bus
    pipe_mem_wb_if.master         mem_bus,

    // MEM/WB register
    output logic                  REGWRITE_OUT,
    output logic                  MEMTOREG_OUT,
    output logic [WIDTH-1:0]      RESULTOP_OUT,
    output logic [WIDTH-1:0]      RDATA_OUT,
    output logic [4:0]            ARD_OUT
`ifdef MEM_MISALIGN_EN
    ,
    output logic                  MISALIGN_OUT
`endif
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;

    // Decode of the instruction sitting in EX/MEM
    logic             w_memop;
    logic             w_misalign;

    // FSM outputs
    logic             w_stall;
    logic             w_issue;      // launch a bus request at the next edge
    logic             w_done;       // access completes at the next edge
    logic             w_wb_load;    // MEM/WB takes the EX/MEM instruction

    // Bus request registers
    logic             r_mem_req;
    logic             r_mem_we;
    logic [WIDTH-1:0] r_mem_addr;
    logic [WIDTH-1:0] r_mem_wdata;

    // MEM/WB registers
    logic             r_regwrite;
    logic             r_memtoreg;
    logic [WIDTH-1:0] r_resultop;
    logic [WIDTH-1:0] r_rdata;
    logic [4:0]       r_ard;

    // A store takes priority over a load when both flags are set. Both of
    // them still need the bus, so one OR covers both cases.
    assign w_memop = MEMWRITE_IN | MEMTOREG_IN;

`ifdef MEM_MISALIGN_EN
    logic r_misalign;

    // Only word-aligned accesses reach the bus
    assign w_misalign   = w_memop & (RESULTOP_IN[1:0] != 2'b00);
    assign MISALIGN_OUT = r_misalign;
`else
    // The low address bits go to the bus without a check
    assign w_misalign = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    // Reset abandons any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------
    // Enter ACCESS for an aligned memop and return to IDLE on the ack
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_memop && !w_misalign) begin
                    w_state_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mem_bus.MEM_ACK) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: output decode
    // ------------------------------------------------------------------
    // The stall drops in the same cycle as the ack so that upstream
    // advances at the edge that retires the access. An ack seen in IDLE
    // has no effect.
    always_comb begin
        w_stall   = 1'b0;
        w_issue   = 1'b0;
        w_done    = 1'b0;
        w_wb_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_memop && !w_misalign) begin
                    w_issue = 1'b1;
                    w_stall = 1'b1;
                end else begin
                    w_wb_load = 1'b1;
                end
            end
            S_ACCESS: begin
                if (mem_bus.MEM_ACK) begin
                    w_done    = 1'b1;
                    w_wb_load = 1'b1;
                end else begin
                    w_stall   = 1'b1;
                end
            end
            default: begin
                w_stall = 1'b0;
            end
        endcase
    end

    // The stall is masked while reset is asserted, so every output reads
    // zero during reset.
    assign STALL_OUT = w_stall & rst;

    // ------------------------------------------------------------------
    // Bus request register
    // ------------------------------------------------------------------
    // Capture the request once and keep it stable until the ack. Only one
    // access is ever outstanding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_issue) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= MEMWRITE_IN;
            r_mem_addr  <= RESULTOP_IN;
            r_mem_wdata <= WRDATA_IN;
        end else if (w_done) begin
            r_mem_req   <= 1'b0;
        end
    end

    assign mem_bus.MEM_REQ   = r_mem_req;
    assign mem_bus.MEM_WE    = r_mem_we;
    assign mem_bus.MEM_ADDR  = r_mem_addr;
    assign mem_bus.MEM_WDATA = r_mem_wdata;

    // ------------------------------------------------------------------
    // MEM/WB register
    // ------------------------------------------------------------------
    // Load the instruction when it retires; otherwise clear the write
    // controls (bubble) and keep the data fields. Load data is captured
    // only at the completion of a read. The registered direction stays
    // valid for the whole access because EX/MEM is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_resultop <= '0;
            r_rdata    <= '0;
            r_ard      <= 5'b0;
        end else if (w_wb_load) begin
            r_regwrite <= REGWRITE_IN & ~w_misalign;
            r_memtoreg <= MEMTOREG_IN;
            r_resultop <= RESULTOP_IN;
            r_ard      <= ARD_IN;
            if (w_done && !r_mem_we) begin
                r_rdata <= mem_bus.MEM_RDATA;
            end
        end else begin
            r_regwrite <= 1'b0;
            r_memtoreg <= 1'b0;
        end
    end

`ifdef MEM_MISALIGN_EN
    // Flag goes high only on an instruction retired as misaligned
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_misalign <= 1'b0;
        end else if (w_wb_load) begin
            r_misalign <= w_misalign;
        end else begin
            r_misalign <= 1'b0;
        end
    end
`endif

    assign REGWRITE_OUT = r_regwrite;
    assign MEMTOREG_OUT = r_memtoreg;
    assign RESULTOP_OUT = r_resultop;
    assign RDATA_OUT    = r_rdata;
    assign ARD_OUT      = r_ard;

endmodule

`default_nettype wire

// File: tb/tb_pipe_mem_wb.sv
// ============================================================================
//  Module      : tb_pipe_mem_wb
//  Description : Self-checking bench for pipe_mem_wb. A table of
//                instructions is applied in order, and the bench acts as the
//                memory responder with a per-vector ack delay. A queue holds
//                the expected MEM/WB contents, and hand-written sequences
//                cover reset during an access, an ack while IDLE,
//                back-to-back operations and misalignment.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_mem_wb;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             MEMWRITE_IN;
    logic             MEMTOREG_IN;
    logic             REGWRITE_IN;
    logic [WIDTH-1:0] RESULTOP_IN;
    logic [WIDTH-1:0] WRDATA_IN;
    logic [4:0]       ARD_IN;
    logic             STALL_OUT;
    logic             REGWRITE_OUT;
    logic             MEMTOREG_OUT;
    logic [WIDTH-1:0] RESULTOP_OUT;
    logic [WIDTH-1:0] RDATA_OUT;
    logic [4:0]       ARD_OUT;
`ifdef MEM_MISALIGN_EN
    logic             MISALIGN_OUT;
`endif

    pipe_mem_wb_if #(.WIDTH(WIDTH)) bus ();

    pipe_mem_wb #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .MEMWRITE_IN  (MEMWRITE_IN),
        .MEMTOREG_IN  (MEMTOREG_IN),
        .REGWRITE_IN  (REGWRITE_IN),
        .RESULTOP_IN  (RESULTOP_IN),
        .WRDATA_IN    (WRDATA_IN),
        .ARD_IN       (ARD_IN),
        .STALL_OUT    (STALL_OUT),
        .mem_bus      (bus),
        .REGWRITE_OUT (REGWRITE_OUT),
        .MEMTOREG_OUT (MEMTOREG_OUT),
        .RESULTOP_OUT (RESULTOP_OUT),
        .RDATA_OUT    (RDATA_OUT),
        .ARD_OUT      (ARD_OUT)
`ifdef MEM_MISALIGN_EN
        ,
        .MISALIGN_OUT (MISALIGN_OUT)
`endif
    );

    // One input vector: the instruction, the ack delay in cycles and the
    // read data that the memory returns
    typedef struct {
        logic        mw;
        logic        m2r;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  ard;
        int          waitc;
        logic [31:0] rdata;
    } vec_t;

    // Expected MEM/WB contents for one retired instruction
    typedef struct {
        logic        rw;
        logic        m2r;
        logic [31:0] res;
        logic [31:0] rdata;
        logic [4:0]  ard;
    } wb_t;

    wb_t         sb[$];
    logic [31:0] exp_rdata;
    int          n_cmp;
    int          n_fail;
    int          req_count;
    logic        req_prev;

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges of MEM_REQ, sampled away from the active edge
    initial begin
        req_count = 0;
        req_prev  = 1'b0;
    end
    always @(negedge clk) begin
        if (bus.MEM_REQ && !req_prev) req_count = req_count + 1;
        req_prev = bus.MEM_REQ;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance one clock. If the stall was low before the edge, the edge
    // retires an instruction and the oldest expectation is compared.
    // Otherwise the edge must have written a bubble.
    task automatic tick();
        logic loading;
        wb_t  e;
        loading = !STALL_OUT;
        @(posedge clk);
        #1;
        if (loading) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wb_regwrite", {31'd0, REGWRITE_OUT}, {31'd0, e.rw});
                chk("wb_memtoreg", {31'd0, MEMTOREG_OUT}, {31'd0, e.m2r});
                chk("wb_resultop", RESULTOP_OUT, e.res);
                chk("wb_rdata", RDATA_OUT, e.rdata);
                chk("wb_ard", {27'd0, ARD_OUT}, {27'd0, e.ard});
`ifdef MEM_MISALIGN_EN
                chk("wb_misalign", {31'd0, MISALIGN_OUT}, 32'd0);
`endif
            end
        end else begin
            chk("bubble_regwrite", {31'd0, REGWRITE_OUT}, 32'd0);
            chk("bubble_memtoreg", {31'd0, MEMTOREG_OUT}, 32'd0);
        end
    endtask

    // Present one instruction and act as the memory until it retires.
    // Entry point and exit point are both 1 time unit after a rising edge.
    task automatic apply(input vec_t v);
        wb_t  e;
        logic memop;
        memop       = v.mw | v.m2r;
        MEMWRITE_IN = v.mw;
        MEMTOREG_IN = v.m2r;
        REGWRITE_IN = v.rw;
        RESULTOP_IN = v.addr;
        WRDATA_IN   = v.wdata;
        ARD_IN      = v.ard;
        bus.MEM_ACK = 1'b0;
        if (!v.mw && v.m2r) exp_rdata = v.rdata;
        e.rw    = v.rw;
        e.m2r   = v.m2r;
        e.res   = v.addr;
        e.rdata = exp_rdata;
        e.ard   = v.ard;
        sb.push_back(e);
        #1;
        chk("stall_first", {31'd0, STALL_OUT}, {31'd0, memop});
        if (!memop) begin
            tick();
            chk("no_req_alu", {31'd0, bus.MEM_REQ}, 32'd0);
        end else begin
            tick();
            chk("req_issue", {31'd0, bus.MEM_REQ}, 32'd1);
            chk("req_we", {31'd0, bus.MEM_WE}, {31'd0, v.mw});
            chk("req_addr", bus.MEM_ADDR, v.addr);
            chk("req_wdata", bus.MEM_WDATA, v.wdata);
            for (int w = 0; w < v.waitc; w++) begin
                bus.MEM_RDATA = $urandom;
                #1;
                chk("stall_wait", {31'd0, STALL_OUT}, 32'd1);
                tick();
                chk("hold_req", {31'd0, bus.MEM_REQ}, 32'd1);
                chk("hold_addr", bus.MEM_ADDR, v.addr);
                chk("hold_wdata", bus.MEM_WDATA, v.wdata);
            end
            bus.MEM_ACK   = 1'b1;
            bus.MEM_RDATA = v.rdata;
            #1;
            chk("stall_ack", {31'd0, STALL_OUT}, 32'd0);
            tick();
            bus.MEM_ACK   = 1'b0;
            bus.MEM_RDATA = $urandom;
            chk("req_drop", {31'd0, bus.MEM_REQ}, 32'd0);
        end
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    vec_t tbl[6];
    vec_t v;
    int   rc0;

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        exp_rdata = 32'h0;

        tbl[0] = '{1'b0, 1'b0, 1'b1, 32'h12345678, 32'h0,        5'b01010, 0, 32'h0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h00000040, 32'h0,        5'b10101, 0, 32'hA5A5A5A5};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h00000080, 32'h55555555, 5'b00011, 3, 32'h0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0,        5'b11111, 0, 32'h0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h00001000, 32'h0,        5'b00001, 2, 32'h0BADF00D};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 32'h00000200, 32'hCAFEBABE, 5'b00111, 1, 32'h0};

        rst           = 1'b0;
        MEMWRITE_IN   = 1'b0;
        MEMTOREG_IN   = 1'b0;
        REGWRITE_IN   = 1'b0;
        RESULTOP_IN   = '0;
        WRDATA_IN     = '0;
        ARD_IN        = '0;
        bus.MEM_ACK   = 1'b0;
        bus.MEM_RDATA = '0;

        // Reset state
        #1;
        chk("rst_req", {31'd0, bus.MEM_REQ}, 32'd0);
        chk("rst_stall", {31'd0, STALL_OUT}, 32'd0);
        chk("rst_regwrite", {31'd0, REGWRITE_OUT}, 32'd0);
        chk("rst_resultop", RESULTOP_OUT, 32'd0);
        chk("rst_rdata", RDATA_OUT, 32'd0);
        chk("rst_ard", {27'd0, ARD_OUT}, 32'd0);
        #10;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven run, in order
        for (int i = 0; i < 6; i++) begin
            apply(tbl[i]);
        end

        // An ack while IDLE must not capture data or issue a request
        MEMWRITE_IN   = 1'b0;
        MEMTOREG_IN   = 1'b0;
        REGWRITE_IN   = 1'b1;
        RESULTOP_IN   = 32'h0000_0ABC;
        ARD_IN        = 5'b00100;
        bus.MEM_ACK   = 1'b1;
        bus.MEM_RDATA = 32'hDEADBEEF;
        sb.push_back('{1'b1, 1'b0, 32'h0000_0ABC, exp_rdata, 5'b00100});
        #1;
        chk("idle_ack_stall", {31'd0, STALL_OUT}, 32'd0);
        tick();
        chk("idle_ack_noreq", {31'd0, bus.MEM_REQ}, 32'd0);
        bus.MEM_ACK = 1'b0;

        // Back-to-back: a load followed by an ALU op makes exactly one request
        rc0 = req_count;
        v = '{1'b0, 1'b1, 1'b1, 32'h00000100, 32'h0, 5'b01100, 0, 32'h13579BDF};
        apply(v);
        v = '{1'b0, 1'b0, 1'b1, 32'h87654321, 32'h0, 5'b01101, 0, 32'h0};
        apply(v);
        @(negedge clk);
        chk("b2b_req_count", req_count - rc0, 32'd1);
        @(posedge clk);
        #1;

        // Reset during ACCESS clears the outputs before any edge
        v = '{1'b0, 1'b1, 1'b1, 32'h00000300, 32'h0, 5'b11000, 0, 32'h0};
        MEMWRITE_IN = v.mw;
        MEMTOREG_IN = v.m2r;
        REGWRITE_IN = v.rw;
        RESULTOP_IN = v.addr;
        ARD_IN      = v.ard;
        @(posedge clk);
        #1;
        chk("mid_req_up", {31'd0, bus.MEM_REQ}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, bus.MEM_REQ}, 32'd0);
        chk("mid_rst_addr", bus.MEM_ADDR, 32'd0);
        chk("mid_rst_stall", {31'd0, STALL_OUT}, 32'd0);
        chk("mid_rst_rdata", RDATA_OUT, 32'd0);
        chk("mid_rst_resultop", RESULTOP_OUT, 32'd0);
        chk("mid_rst_ard", {27'd0, ARD_OUT}, 32'd0);
        MEMWRITE_IN = 1'b0;
        MEMTOREG_IN = 1'b0;
        REGWRITE_IN = 1'b0;
        RESULTOP_IN = '0;
        ARD_IN      = '0;
        sb.delete();
        exp_rdata = 32'h0;
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_regwrite", {31'd0, REGWRITE_OUT}, 32'd0);

`ifdef MEM_MISALIGN_EN
        // A misaligned load issues no request and retires as misaligned
        rc0 = req_count;
        MEMWRITE_IN = 1'b0;
        MEMTOREG_IN = 1'b1;
        REGWRITE_IN = 1'b1;
        RESULTOP_IN = 32'h00000042;
        ARD_IN      = 5'b00010;
        #1;
        chk("mis_stall", {31'd0, STALL_OUT}, 32'd0);
        @(posedge clk);
        #1;
        chk("mis_req", {31'd0, bus.MEM_REQ}, 32'd0);
        chk("mis_flag", {31'd0, MISALIGN_OUT}, 32'd1);
        chk("mis_regwrite", {31'd0, REGWRITE_OUT}, 32'd0);
        MEMTOREG_IN = 1'b0;
        @(posedge clk);
        #1;
        chk("mis_clear", {31'd0, MISALIGN_OUT}, 32'd0);
        chk("mis_no_req_cnt", req_count - rc0, 32'd0);
`endif

        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_mem_wb.md
Name: pipe_mem_wb

Overview:
- MEM stage plus MEM/WB pipeline register of the 32-bit pipelined core.
- Consumes the EX/MEM register outputs (MEMWRITE, MEMTOREG, REGWRITE, RESULTOP, WRDATA, ARD).
- Performs the data-memory access over a req/ack bus, stalling upstream until the access completes.
- Registers the writeback bundle (control, ALU result, load data, destination register) for the WB stage.

Parameters:
- WIDTH, 32, data/address width of RESULTOP, WRDATA and the memory bus.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately).
- MEMWRITE_IN  in  1  store request from EX/MEM.
- MEMTOREG_IN  in  1  load request / writeback-select from EX/MEM.
- REGWRITE_IN  in  1  register-write enable from EX/MEM.
- RESULTOP_IN  in  WIDTH  ALU result; memory address for loads/stores.
- WRDATA_IN  in  WIDTH  store data.
- ARD_IN  in  5  destination register address.
- STALL_OUT  out  1  combinational; upstream holds EX/MEM contents while 1.
- MEM_REQ  out  1  registered bus request.
- MEM_WE  out  1  registered; 1=write, 0=read.
- MEM_ADDR  out  WIDTH  registered access address.
- MEM_WDATA  out  WIDTH  registered store data.
- MEM_RDATA  in  WIDTH  read data, valid when MEM_ACK=1.
- MEM_ACK  in  1  access complete, one-cycle pulse.
- REGWRITE_OUT  out  1  MEM/WB register-write enable.
- MEMTOREG_OUT  out  1  MEM/WB select: 1=RDATA_OUT, 0=RESULTOP_OUT.
- RESULTOP_OUT  out  WIDTH  registered ALU result.
- RDATA_OUT  out  WIDTH  registered load data.
- ARD_OUT  out  5  registered destination register.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. MEM_REQ, MEM_WE, REGWRITE_OUT and MEMTOREG_OUT are 0. MEM_ADDR, MEM_WDATA, RESULTOP_OUT and RDATA_OUT are 0. ARD_OUT is 5'b0. STALL_OUT is 0.
- Op decode: memop = MEMWRITE_IN | MEMTOREG_IN. MEMWRITE_IN=1 means store, with priority over load even if MEMTOREG_IN=1. Otherwise MEMTOREG_IN=1 means load.
- FSM states: IDLE, ACCESS.
- IDLE, memop=0:
  - STALL_OUT=0.
  - Next edge loads MEM/WB from inputs; RDATA_OUT holds its previous value.
  - Latency is 1 cycle.
- IDLE, memop=1:
  - STALL_OUT=1.
  - Next edge: MEM_REQ=1, MEM_WE=MEMWRITE_IN, MEM_ADDR=RESULTOP_IN, MEM_WDATA=WRDATA_IN; go to ACCESS.
  - MEM/WB loads a bubble: REGWRITE_OUT=0, MEMTOREG_OUT=0, other fields hold.
- ACCESS, MEM_ACK=0:
  - STALL_OUT=1; MEM_REQ and address/data held stable.
  - MEM/WB keeps loading bubbles.
- ACCESS, MEM_ACK=1:
  - STALL_OUT=0, combinational from MEM_ACK.
  - Next edge: MEM_REQ=0, MEM/WB loads from inputs, RDATA_OUT=MEM_RDATA if load (held if store); go to IDLE.
  - Minimum memory-op latency is 2 cycles (1 stall cycle) with zero-wait ack.
- Any MEM_ACK seen in IDLE is ignored.
- Store with REGWRITE_IN=1 passes REGWRITE_IN through unchanged; no filtering.
- Back-to-back memops: the IDLE cycle after an ack re-evaluates the new inputs. No request overlap; at most one outstanding access.
- Reset mid-ACCESS: MEM_REQ drops immediately and the access is abandoned. No writeback occurs for it.
- No flush input; WB never sees a valid instruction twice because stall cycles emit bubbles.

Optional Feature:
- Macro MEM_MISALIGN_EN.
- With the macro:
  - Adds port MISALIGN_OUT (out, 1), reset 0.
  - A memop with RESULTOP_IN[1:0]!=2'b00 issues no bus request and has STALL_OUT=0.
  - Next edge loads MEM/WB with REGWRITE_OUT=0 and MISALIGN_OUT=1.
  - MISALIGN_OUT is 0 for every other loaded instruction.
- Without the macro:
  - No MISALIGN_OUT port.
  - Address bits [1:0] are passed to MEM_ADDR unchecked.

Test Plan:
- Reset: rst=0 during MEM_REQ=1 -> MEM_REQ=0 and all outputs 0 immediately, before any clock edge.
- ALU op: REGWRITE_IN=1, RESULTOP_IN=32'h12345678, ARD_IN=5'b01010 -> next edge REGWRITE_OUT=1, RESULTOP_OUT=32'h12345678, ARD_OUT=5'b01010, STALL_OUT never 1.
- Load with zero-wait ack:
  - Stimulus: MEMTOREG_IN=1, REGWRITE_IN=1, RESULTOP_IN=32'h00000040, ARD_IN=5'b10101, MEM_ACK=1 with MEM_RDATA=32'hA5A5A5A5 on the first ACCESS cycle.
  - Response: STALL_OUT=1 for 1 cycle, MEM_WE=0, MEM_ADDR=32'h40, then RDATA_OUT=32'hA5A5A5A5, MEMTOREG_OUT=1, REGWRITE_OUT=1.
- Store with 3 wait cycles:
  - Stimulus: MEMWRITE_IN=1, MEMTOREG_IN=1, WRDATA_IN=32'h55555555, RESULTOP_IN=32'h00000080; ack delayed 3 cycles.
  - Response: MEM_WE=1, MEM_WDATA=32'h55555555 held stable 4 cycles, STALL_OUT=1 for 4 cycles, REGWRITE_OUT=0 on every stall edge, single MEM_REQ pulse train.
- Back-to-back: load then ALU op -> exactly one bus request, ALU op appears in MEM/WB one edge after the load.
- MEM_MISALIGN_EN: load at 32'h00000042 -> MEM_REQ stays 0, next edge MISALIGN_OUT=1 and REGWRITE_OUT=0.
